// File: rtl/mcb_ref_sched_pkg.sv
// Shared timing, sizing and state definitions for the MCB refresh scheduler.
package mcb_ref_sched_pkg;

  // Timing in mcb_clk cycles
  localparam int CtRP      = 2;  // precharge-to-refresh wait
  localparam int CtRFC     = 7;  // refresh-to-next-command wait

  // Pending-refresh bookkeeping
  localparam int MAX_PEND  = 8;  // saturation limit of the debt counter
  localparam int URGENT_TH = 6;  // debt at/above which refresh is forced
  localparam int PEND_W    = 4;  // width of the debt counter
  localparam int TMR_W     = 4;  // width of the wait timer

  // Width-matched constants so comparisons and loads stay lint-clean
  localparam logic [PEND_W-1:0] MAX_PEND_C  = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] URGENT_TH_C = PEND_W'(URGENT_TH);
  localparam logic [TMR_W-1:0]  TRP_LOAD    = TMR_W'(CtRP - 1);
  localparam logic [TMR_W-1:0]  TRFC_LOAD   = TMR_W'(CtRFC - 1);

  // Scheduler sequence states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_PREA = 3'd2,
    ST_WRP  = 3'd3,
    ST_REF  = 3'd4,
    ST_WRFC = 3'd5
  } ref_state_t;

endpackage

// File: rtl/mcb_ref_sched_if.sv
// Refresh-scheduler signal bundle: interval-counter handshake, front-end
// status, command-bus arbitration and command strobes.
interface mcb_ref_sched_if;
  import mcb_ref_sched_pkg::*;

  logic              ref_alert;
  logic              ref_ack;
  logic              user_pend;
  logic              bank_open;
  logic              bus_gnt;
  logic              bus_req;
  logic              cmd_prea;
  logic              cmd_ref;
  logic              user_hold;
  logic [PEND_W-1:0] ref_pend;
  logic              ref_ovf;

  // Scheduler side
  modport slave (
    input  ref_alert, user_pend, bank_open, bus_gnt,
    output ref_ack, bus_req, cmd_prea, cmd_ref, user_hold, ref_pend, ref_ovf
  );

  // Surrounding controller side
  modport master (
    output ref_alert, user_pend, bank_open, bus_gnt,
    input  ref_ack, bus_req, cmd_prea, cmd_ref, user_hold, ref_pend, ref_ovf
  );

endinterface

// File: rtl/mcb_ref_wait_tmr.sv
// Loadable down-counter with a zero flag; times both the tRP and tRFC waits.
module mcb_ref_wait_tmr
  import mcb_ref_sched_pkg::*;
(
  input  logic             mcb_clk,
  input  logic             mcb_rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_reg;

  // Load has priority over counting; the count parks at zero
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mcb_ref_sched.sv
// Refresh scheduler: turns interval alerts into refresh debt, then wins the
// command bus and issues PREA / REF with tRP / tRFC spacing, postponing for
// user traffic until the debt becomes urgent.
module mcb_ref_sched
  import mcb_ref_sched_pkg::*;
(
  input  logic            mcb_clk,
  input  logic            mcb_rst_n,
  input  logic            mcb_sclr_n,
  input  logic            i_ready,
  mcb_ref_sched_if.slave  rs
);

  ref_state_t        state_reg, state_next;
  logic [PEND_W-1:0] count_reg, count_next;
  logic              ack_reg;
  logic              ovf_reg, ovf_next;
  logic              hold_reg;

  logic clr;        // synchronous wipe: sclr or SDRAM not initialised
  logic inc;        // alert being acknowledged this cycle
  logic dec;        // refresh issued this cycle
  logic urgent;
  logic may_go;     // debt exists and refresh is allowed to run now
  logic tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val;

  assign clr    = !mcb_sclr_n || !i_ready;
  assign inc    = rs.ref_alert && !ack_reg;
  assign dec    = (state_reg == ST_REF);
  assign urgent = (count_reg >= URGENT_TH_C);
  assign may_go = (count_reg != '0) && (urgent || !rs.user_pend);

  // Debt counter update: ack adds, REF subtracts, both together cancel
  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (inc && !dec) begin
      if (count_reg == MAX_PEND_C) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (dec && !inc && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Alert acknowledge, debt, overflow and urgency registers
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      ack_reg   <= 1'b0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      hold_reg  <= 1'b0;
    end else if (clr) begin
      ack_reg   <= 1'b0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      hold_reg  <= 1'b0;
    end else begin
      ack_reg   <= inc;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      hold_reg  <= urgent;
    end
  end

  // Sequence state register
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      state_reg <= ST_IDLE;
    end else if (clr) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and wait-timer control
  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (may_go) state_next = ST_REQ;
      end
      ST_REQ: begin
        // Once granted the bus stays ours until the sequence ends
        if (rs.bus_gnt) state_next = rs.bank_open ? ST_PREA : ST_REF;
      end
      ST_PREA: begin
        tmr_load   = 1'b1;
        tmr_val    = TRP_LOAD;
        state_next = ST_WRP;
      end
      ST_WRP: begin
        if (tmr_zero) state_next = ST_REF;
        else          tmr_en     = 1'b1;
      end
      ST_REF: begin
        tmr_load   = 1'b1;
        tmr_val    = TRFC_LOAD;
        state_next = ST_WRFC;
      end
      ST_WRFC: begin
        // Banks are already closed, so a follow-on refresh skips PREA
        if (tmr_zero) state_next = may_go ? ST_REF : ST_IDLE;
        else          tmr_en     = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mcb_ref_wait_tmr u_wait_tmr (
    .mcb_clk   (mcb_clk),
    .mcb_rst_n (mcb_rst_n),
    .clr       (clr),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .en        (tmr_en),
    .zero      (tmr_zero)
  );

  assign rs.ref_ack   = ack_reg;
  assign rs.bus_req   = (state_reg != ST_IDLE);
  assign rs.cmd_prea  = (state_reg == ST_PREA);
  assign rs.cmd_ref   = (state_reg == ST_REF);
  assign rs.user_hold = hold_reg;
  assign rs.ref_pend  = count_reg;
  assign rs.ref_ovf   = ovf_reg;

endmodule

// File: tb/tb_mcb_ref_sched.sv
// Directed bench for mcb_ref_sched: single refresh with and without PREA,
// postponement and urgency, saturation/overflow, coincident ack/REF,
// i_ready drop and asynchronous reset.
module tb_mcb_ref_sched;
  import mcb_ref_sched_pkg::*;

  logic mcb_clk = 1'b0;
  logic mcb_rst_n;
  logic mcb_sclr_n;
  logic i_ready;

  int n_assert = 0;
  int n_fail   = 0;

  mcb_ref_sched_if ifc ();

  mcb_ref_sched dut (
    .mcb_clk    (mcb_clk),
    .mcb_rst_n  (mcb_rst_n),
    .mcb_sclr_n (mcb_sclr_n),
    .i_ready    (i_ready),
    .rs         (ifc.slave)
  );

  always #5 mcb_clk = ~mcb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge mcb_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One alert: ack lands on the first edge, alert withdrawn for the second
  task automatic alert_pulse();
    ifc.ref_alert = 1'b1;
    tick();
    ifc.ref_alert = 1'b0;
    tick();
  endtask

  initial begin
    int n_ref, n_prea, first_ref, last_ref, prev_ref;

    mcb_rst_n     = 1'b0;
    mcb_sclr_n    = 1'b1;
    i_ready       = 1'b1;
    ifc.ref_alert = 1'b0;
    ifc.user_pend = 1'b0;
    ifc.bank_open = 1'b0;
    ifc.bus_gnt   = 1'b1;

    // Reset state
    #12;
    check("rst_bus_req", 32'(ifc.bus_req), 32'd0);
    check("rst_ref_ack", 32'(ifc.ref_ack), 32'd0);
    check("rst_ref_pend", 32'(ifc.ref_pend), 32'd0);
    check("rst_ref_ovf", 32'(ifc.ref_ovf), 32'd0);
    tick();
    mcb_rst_n = 1'b1;
    tick();

    // Single alert, idle user, banks closed
    ifc.ref_alert = 1'b1;
    tick();
    check("t1_ack", 32'(ifc.ref_ack), 32'd1);
    check("t1_pend1", 32'(ifc.ref_pend), 32'd1);
    check("t1_noreq_yet", 32'(ifc.bus_req), 32'd0);
    ifc.ref_alert = 1'b0;
    tick();
    check("t1_ack_single", 32'(ifc.ref_ack), 32'd0);
    check("t1_req", 32'(ifc.bus_req), 32'd1);
    check("t1_noref_in_req", 32'(ifc.cmd_ref), 32'd0);
    tick();
    check("t1_ref", 32'(ifc.cmd_ref), 32'd1);
    check("t1_noprea", 32'(ifc.cmd_prea), 32'd0);
    tick();
    check("t1_ref_one_cycle", 32'(ifc.cmd_ref), 32'd0);
    check("t1_pend0", 32'(ifc.ref_pend), 32'd0);
    ticks(6);
    check("t1_req_last_wrfc", 32'(ifc.bus_req), 32'd1);
    tick();
    check("t1_req_drop", 32'(ifc.bus_req), 32'd0);

    // Single alert with a bank open: PREA then REF three cycles later
    ifc.bank_open = 1'b1;
    alert_pulse();
    check("t2_req", 32'(ifc.bus_req), 32'd1);
    tick();
    check("t2_prea", 32'(ifc.cmd_prea), 32'd1);
    check("t2_noref", 32'(ifc.cmd_ref), 32'd0);
    tick();
    check("t2_prea_one_cycle", 32'(ifc.cmd_prea), 32'd0);
    tick();
    check("t2_noref_wrp", 32'(ifc.cmd_ref), 32'd0);
    ifc.bank_open = 1'b0;
    tick();
    check("t2_ref_at_3", 32'(ifc.cmd_ref), 32'd1);
    n_ref  = 0;
    n_prea = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifc.cmd_ref)  n_ref++;
      if (ifc.cmd_prea) n_prea++;
    end
    check("t2_no_extra_strobes", 32'(n_ref + n_prea), 32'd0);
    check("t2_idle", 32'(ifc.bus_req), 32'd0);
    check("t2_pend0", 32'(ifc.ref_pend), 32'd0);

    // Postponement under user traffic, then urgency at six
    ifc.user_pend = 1'b1;
    for (int k = 0; k < 5; k++) alert_pulse();
    check("t3_pend5", 32'(ifc.ref_pend), 32'd5);
    check("t3_noreq", 32'(ifc.bus_req), 32'd0);
    check("t3_nohold", 32'(ifc.user_hold), 32'd0);
    ifc.ref_alert = 1'b1;
    tick();
    check("t3_pend6", 32'(ifc.ref_pend), 32'd6);
    check("t3_hold_lat", 32'(ifc.user_hold), 32'd0);
    ifc.ref_alert = 1'b0;
    tick();
    check("t3_hold", 32'(ifc.user_hold), 32'd1);
    check("t3_urgent_req", 32'(ifc.bus_req), 32'd1);
    // Front end drains once user grants are held off
    ifc.user_pend = 1'b0;
    n_ref     = 0;
    first_ref = -1;
    last_ref  = -1;
    prev_ref  = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ifc.cmd_ref) begin
        n_ref++;
        if (first_ref < 0) first_ref = i;
        if (prev_ref >= 0) check("t3_ref_gap", 32'(i - prev_ref), 32'd8);
        prev_ref = i;
        last_ref = i;
      end
    end
    check("t3_ref_count", 32'(n_ref), 32'd6);
    check("t3_first_ref", 32'(first_ref), 32'd1);
    check("t3_span", 32'(last_ref - first_ref), 32'd40);
    check("t3_pend0", 32'(ifc.ref_pend), 32'd0);
    check("t3_hold_off", 32'(ifc.user_hold), 32'd0);
    check("t3_idle", 32'(ifc.bus_req), 32'd0);

    // Saturation and sticky overflow with no grant
    ifc.user_pend = 1'b1;
    ifc.bus_gnt   = 1'b0;
    for (int k = 0; k < 8; k++) alert_pulse();
    check("t4_pend8", 32'(ifc.ref_pend), 32'd8);
    check("t4_no_ovf_yet", 32'(ifc.ref_ovf), 32'd0);
    alert_pulse();
    check("t4_pend_sat", 32'(ifc.ref_pend), 32'd8);
    check("t4_ovf", 32'(ifc.ref_ovf), 32'd1);
    ticks(5);
    check("t4_ovf_sticky", 32'(ifc.ref_ovf), 32'd1);
    check("t4_hold", 32'(ifc.user_hold), 32'd1);
    check("t4_req_wait", 32'(ifc.bus_req), 32'd1);
    check("t4_no_ref", 32'(ifc.cmd_ref), 32'd0);
    mcb_sclr_n = 1'b0;
    tick();
    check("t4_sclr_ovf", 32'(ifc.ref_ovf), 32'd0);
    check("t4_sclr_pend", 32'(ifc.ref_pend), 32'd0);
    check("t4_sclr_req", 32'(ifc.bus_req), 32'd0);
    check("t4_sclr_hold", 32'(ifc.user_hold), 32'd0);
    mcb_sclr_n = 1'b1;
    tick();
    check("t4_ovf_stays_clear", 32'(ifc.ref_ovf), 32'd0);

    // Alert acknowledged in the same cycle a REF is issued
    ifc.bus_gnt = 1'b1;
    alert_pulse();
    alert_pulse();
    check("t5_pend2", 32'(ifc.ref_pend), 32'd2);
    check("t5_noreq", 32'(ifc.bus_req), 32'd0);
    ifc.user_pend = 1'b0;
    tick();
    check("t5_req", 32'(ifc.bus_req), 32'd1);
    tick();
    check("t5_ref", 32'(ifc.cmd_ref), 32'd1);
    check("t5_pend_in_ref", 32'(ifc.ref_pend), 32'd2);
    ifc.ref_alert = 1'b1;
    tick();
    check("t5_ack", 32'(ifc.ref_ack), 32'd1);
    check("t5_pend_net", 32'(ifc.ref_pend), 32'd2);
    ifc.ref_alert = 1'b0;
    ifc.user_pend = 1'b1;
    ticks(8);
    check("t5_idle", 32'(ifc.bus_req), 32'd0);
    check("t5_pend_kept", 32'(ifc.ref_pend), 32'd2);

    // i_ready dropped while waiting out tRFC
    ifc.user_pend = 1'b0;
    ticks(2);
    check("t6_ref", 32'(ifc.cmd_ref), 32'd1);
    tick();
    check("t6_pend1", 32'(ifc.ref_pend), 32'd1);
    tick();
    check("t6_in_wrfc", 32'(ifc.bus_req), 32'd1);
    i_ready       = 1'b0;
    ifc.user_pend = 1'b1;
    tick();
    check("t6_req0", 32'(ifc.bus_req), 32'd0);
    check("t6_pend0", 32'(ifc.ref_pend), 32'd0);
    check("t6_ref0", 32'(ifc.cmd_ref), 32'd0);
    check("t6_state", 32'(dut.state_reg), 32'(ST_IDLE));
    i_ready = 1'b1;
    ticks(3);
    check("t6_stays_idle", 32'(ifc.bus_req), 32'd0);

    // Asynchronous reset in the middle of the tRP wait
    ifc.bank_open = 1'b1;
    ifc.user_pend = 1'b0;
    alert_pulse();
    tick();
    check("t7_prea", 32'(ifc.cmd_prea), 32'd1);
    tick();
    check("t7_in_wrp", 32'(ifc.bus_req), 32'd1);
    #2;
    mcb_rst_n = 1'b0;
    #1;
    check("t7_async_req", 32'(ifc.bus_req), 32'd0);
    check("t7_async_pend", 32'(ifc.ref_pend), 32'd0);
    tick();
    mcb_rst_n = 1'b1;
    n_ref = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifc.cmd_ref) n_ref++;
    end
    check("t7_no_ref_after_rst", 32'(n_ref), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
